// File: rtl/screen_blitter.sv
// Streams one full-screen image (background ROM or solid fill) to vga_adapter, one pixel per clock.
// Optional: define BLIT_TRANSPARENT_EN to suppress plotting of pixels equal to TRANS_COLOUR.
module screen_blitter #(
  parameter int          WIDTH        = 160,
  parameter int          HEIGHT       = 120,
  parameter int          XW           = 8,
  parameter int          YW           = 7,
  parameter int          CW           = 3,
  parameter int          AW           = 15,
  parameter int          ROM_LAT      = 1,
  parameter logic [CW-1:0] TRANS_COLOUR = 3'b000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iStart,
  input  logic [1:0]    iScreenSel,
  input  logic [CW-1:0] iFillColour,
  input  logic [CW-1:0] iRomData,
  output logic [AW-1:0] oRomAddr,
  output logic          oRomSel,
  output logic [XW-1:0] oX,
  output logic [YW-1:0] oY,
  output logic [CW-1:0] oColour,
  output logic          oPlot,
  output logic          oBusy,
  output logic          oDone
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_r;
  logic [XW-1:0]   x_r;
  logic [YW-1:0]   y_r;
  logic [AW-1:0]   addr_r;
  logic            fill_mode_r;
  logic [CW-1:0]   fill_r;
  logic            rom_sel_r;
  logic            busy_r;
  logic            done_r;

  logic [ROM_LAT-1:0] pipe_vld_r;
  logic [XW-1:0]      pipe_x_r [ROM_LAT];
  logic [YW-1:0]      pipe_y_r [ROM_LAT];

  logic            plot_r;
  logic [XW-1:0]   out_x_r;
  logic [YW-1:0]   out_y_r;
  logic [CW-1:0]   out_col_r;

  logic [CW-1:0]   pix_colour_s;
  logic            pix_plot_s;

  // Scan control: handshake, raster counters and linear ROM address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      x_r         <= '0;
      y_r         <= '0;
      addr_r      <= '0;
      fill_mode_r <= 1'b0;
      fill_r      <= '0;
      rom_sel_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (iStart) begin
            fill_mode_r <= iScreenSel[1];
            fill_r      <= iFillColour;
            // The ROM select only moves for ROM screens so the ROM mux stays put during fills.
            if (!iScreenSel[1]) begin
              rom_sel_r <= iScreenSel[0];
            end
            x_r     <= '0;
            y_r     <= '0;
            addr_r  <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (x_r == XW'(WIDTH - 1)) begin
            if (y_r == YW'(HEIGHT - 1)) begin
              state_r <= ST_DRAIN;
            end else begin
              x_r    <= '0;
              y_r    <= y_r + YW'(1);
              addr_r <= addr_r + AW'(1);
            end
          end else begin
            x_r    <= x_r + XW'(1);
            addr_r <= addr_r + AW'(1);
          end
        end
        ST_DRAIN: begin
          if (pipe_vld_r == '0) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Delay line matching the ROM read latency so coordinates line up with iRomData.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_vld_r <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        pipe_x_r[i] <= '0;
        pipe_y_r[i] <= '0;
      end
    end else begin
      pipe_vld_r[0] <= (state_r == ST_RUN);
      pipe_x_r[0]   <= x_r;
      pipe_y_r[0]   <= y_r;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_x_r[i]   <= pipe_x_r[i-1];
        pipe_y_r[i]   <= pipe_y_r[i-1];
      end
    end
  end

  // Pixel colour source: latched fill colour or the ROM word for this pixel.
  always_comb begin
    pix_colour_s = '0;
    if (fill_mode_r) begin
      pix_colour_s = fill_r;
    end else begin
      pix_colour_s = iRomData;
    end
  end

`ifdef BLIT_TRANSPARENT_EN
  assign pix_plot_s = pipe_vld_r[ROM_LAT-1] && (pix_colour_s != TRANS_COLOUR);
`else
  logic trans_unused_s;
  assign trans_unused_s = ^TRANS_COLOUR;
  assign pix_plot_s     = pipe_vld_r[ROM_LAT-1];
`endif

  // Registered pixel output stage; coordinates and colour hold between pixels.
  always_ff @(posedge clock) begin
    if (reset) begin
      plot_r    <= 1'b0;
      out_x_r   <= '0;
      out_y_r   <= '0;
      out_col_r <= '0;
    end else begin
      plot_r <= pix_plot_s;
      if (pipe_vld_r[ROM_LAT-1]) begin
        out_x_r   <= pipe_x_r[ROM_LAT-1];
        out_y_r   <= pipe_y_r[ROM_LAT-1];
        out_col_r <= pix_colour_s;
      end
    end
  end

  assign oRomAddr = addr_r;
  assign oRomSel  = rom_sel_r;
  assign oX       = out_x_r;
  assign oY       = out_y_r;
  assign oColour  = out_col_r;
  assign oPlot    = plot_r;
  assign oBusy    = busy_r;
  assign oDone    = done_r;

endmodule

// File: tb/tb_screen_blitter.sv
// Directed bench for screen_blitter: reset, abort-by-reset, and table-driven full-frame blits.
module tb_screen_blitter;

  localparam int W    = 160;
  localparam int H    = 120;
  localparam int LAT  = 1;
  localparam int NPIX = W * H;

  logic        clock = 1'b0;
  logic        reset;
  logic        iStart;
  logic [1:0]  iScreenSel;
  logic [2:0]  iFillColour;
  logic [2:0]  iRomData;
  logic [14:0] oRomAddr;
  logic        oRomSel;
  logic [7:0]  oX;
  logic [6:0]  oY;
  logic [2:0]  oColour;
  logic        oPlot;
  logic        oBusy;
  logic        oDone;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  screen_blitter #(.ROM_LAT(LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .iStart     (iStart),
    .iScreenSel (iScreenSel),
    .iFillColour(iFillColour),
    .iRomData   (iRomData),
    .oRomAddr   (oRomAddr),
    .oRomSel    (oRomSel),
    .oX         (oX),
    .oY         (oY),
    .oColour    (oColour),
    .oPlot      (oPlot),
    .oBusy      (oBusy),
    .oDone      (oDone)
  );

  // ROM model: loading screen q = addr[2:0], gameover screen q = ~addr[2:0], LAT clocks late.
  logic [2:0] rom_pipe [LAT];
  always @(posedge clock) begin
    rom_pipe[0] <= oRomAddr[2:0] ^ {3{oRomSel}};
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign iRomData = rom_pipe[LAT-1];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [2:0] fill;
    logic       exp_rom_sel;
    logic       disturb;
  } vec_t;

  vec_t vecs [3];

  // One full blit; k counts clock edges after the start edge, sampled on the falling edge.
  task automatic run_blit(input vec_t v);
    int         done_k;
    int         p;
    logic [2:0] exp_col;
    logic       exp_plot;
    done_k = LAT + 1 + NPIX;
    @(negedge clock);
    iScreenSel  = v.sel;
    iFillColour = v.fill;
    iStart      = 1'b1;
    @(posedge clock);
    for (int k = 0; k <= done_k + 2; k++) begin
      @(negedge clock);
      if (k == 0) iStart = 1'b0;
      if (v.disturb && k == 100) begin
        iStart      = 1'b1;
        iScreenSel  = v.sel ^ 2'b10;
        iFillColour = ~v.fill;
      end
      if (v.disturb && k == 101) iStart = 1'b0;
      p = k - (LAT + 1);
      if (p >= 0 && p < NPIX) begin
        exp_col  = v.sel[1] ? v.fill : (3'(p) ^ {3{v.exp_rom_sel}});
        exp_plot = 1'b1;
`ifdef BLIT_TRANSPARENT_EN
        exp_plot = (exp_col != 3'b000);
`endif
        check("plot", int'(oPlot), int'(exp_plot));
        check("x", int'(oX), p % W);
        check("y", int'(oY), p / W);
        check("colour", int'(oColour), int'(exp_col));
      end else begin
        check("plot_idle", int'(oPlot), 0);
      end
      check("done", int'(oDone), int'(k == done_k));
      check("busy", int'(oBusy), int'(k <= done_k));
    end
    check("rom_sel", int'(oRomSel), int'(v.exp_rom_sel));
    check("rom_addr_hold", int'(oRomAddr), NPIX - 1);
  endtask

  initial begin
    vecs[0] = '{sel: 2'd0, fill: 3'b000, exp_rom_sel: 1'b0, disturb: 1'b0};
    vecs[1] = '{sel: 2'd2, fill: 3'b110, exp_rom_sel: 1'b0, disturb: 1'b0};
    vecs[2] = '{sel: 2'd1, fill: 3'b011, exp_rom_sel: 1'b1, disturb: 1'b1};

    reset       = 1'b1;
    iStart      = 1'b0;
    iScreenSel  = 2'd0;
    iFillColour = 3'b000;
    repeat (3) @(negedge clock);
    check("rst_plot", int'(oPlot), 0);
    check("rst_busy", int'(oBusy), 0);
    check("rst_done", int'(oDone), 0);
    check("rst_x", int'(oX), 0);
    check("rst_y", int'(oY), 0);
    check("rst_colour", int'(oColour), 0);
    check("rst_addr", int'(oRomAddr), 0);
    check("rst_rom_sel", int'(oRomSel), 0);
    reset = 1'b0;

    // Abort a gameover blit with reset around pixel 5000.
    @(negedge clock);
    iScreenSel = 2'd1;
    iStart     = 1'b1;
    @(posedge clock);
    for (int k = 0; k <= 5000; k++) begin
      @(negedge clock);
      if (k == 0) iStart = 1'b0;
    end
    check("abort_plot_before", int'(oPlot), 1);
    check("abort_busy_before", int'(oBusy), 1);
    reset = 1'b1;
    @(negedge clock);
    check("abort_plot", int'(oPlot), 0);
    check("abort_busy", int'(oBusy), 0);
    check("abort_done", int'(oDone), 0);
    check("abort_rom_sel", int'(oRomSel), 0);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      check("abort_quiet_plot", int'(oPlot), 0);
      check("abort_quiet_done", int'(oDone), 0);
      check("abort_quiet_busy", int'(oBusy), 0);
    end

    for (int i = 0; i < 3; i++) begin
      run_blit(vecs[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
